seq_alu: RTL and testbench

- Parametrised, handshaked successor to the single-cycle 32-bit ALU.
- Keeps the existing 4-bit ctrl encoding for logic, add, sub and slt.
- Adds signed overflow detection, a correct signed set-less-than, and an iterative shift-add multiplier producing a full 2*WIDTH product.
- Sits between decode and writeback in the multi-cycle datapath; the control FSM stalls on ready_o/valid_o.

---
 rtl/seq_alu_pkg.sv | 34 +++
 rtl/seq_alu_logic.sv | 54 +++++
 rtl/seq_alu.sv | 163 ++++++++++++++++
 tb/tb_seq_alu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// seq_alu_pkg : ctrl codes, FSM state type and op-class helper for seq_alu.
// Option: SEQ_ALU_DIV_EN marks CTRL_DIVU as an iterative op.  Rev 1.0
// ============================================================================
package seq_alu_pkg;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_MUL  = 4'b1000;
    localparam logic [3:0] CTRL_DIVU = 4'b1010;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_NAND = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_iterative(input logic [3:0] ctrl);
`ifdef SEQ_ALU_DIV_EN
        return (ctrl == CTRL_MUL) || (ctrl == CTRL_DIVU);
`else
        return (ctrl == CTRL_MUL);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_logic.sv
`default_nettype none
// ============================================================================
// seq_alu_logic : combinational single-cycle datapath (logic, add, sub, slt).
// Rev 1.0
// ============================================================================
module seq_alu_logic
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] sum_add;
    logic [WIDTH-1:0] sum_sub;
    logic             ovf_add;
    logic             ovf_sub;
    logic             slt;

    assign sum_add = a_i + b_i;
    assign sum_sub = a_i + ~b_i + {{(WIDTH-1){1'b0}}, 1'b1};

    // For SUB the effective B sign is inverted, so "same sign" becomes "differ".
    assign ovf_add = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_add[WIDTH-1] != a_i[WIDTH-1]);
    assign ovf_sub = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sum_sub[WIDTH-1] != a_i[WIDTH-1]);
    assign slt     = sum_sub[WIDTH-1] ^ ovf_sub;

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        case (ctrl_i)
            CTRL_AND:  result_o = a_i & b_i;
            CTRL_OR:   result_o = a_i | b_i;
            CTRL_ADD: begin
                result_o   = sum_add;
                overflow_o = ovf_add;
            end
            CTRL_SUB: begin
                result_o   = sum_sub;
                overflow_o = ovf_sub;
            end
            CTRL_SLT:  result_o = {{(WIDTH-1){1'b0}}, slt};
            CTRL_NOR:  result_o = ~(a_i | b_i);
            CTRL_NAND: result_o = ~(a_i & b_i);
            default:   result_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// seq_alu : handshaked ALU with iterative shift-add multiplier.
// Option: SEQ_ALU_DIV_EN adds a restoring unsigned divider (ctrl 1010). Rev 1.0
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero_o,
    output logic             overflow_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   opb_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               valid_q;
    logic               overflow_q;

    logic               accept;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_ovf;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_d;

    seq_alu_logic #(.WIDTH(WIDTH)) u_logic (
        .a_i        (src1_i),
        .b_i        (src2_i),
        .ctrl_i     (ctrl_i),
        .result_o   (alu_result),
        .overflow_o (alu_ovf)
    );

    assign accept = valid_i && ready_o;

    // Upper half accumulates B (carry kept) before the whole product shifts right.
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    assign mul_d   = {mul_sum, prod_q[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
    // Upper half holds the partial remainder, lower half shifts dividend out / quotient in.
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_d;

    assign div_rem_sh = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_diff   = div_rem_sh - {1'b0, opb_q};
    assign div_ge     = !div_diff[WIDTH];
    assign div_d      = {div_ge ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0],
                         prod_q[WIDTH-2:0], div_ge};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            prod_q      <= '0;
            opb_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_iterative(ctrl_i)) begin
`ifdef SEQ_ALU_DIV_EN
                            if (ctrl_i == CTRL_DIVU) begin
                                if (src2_i == '0) begin
                                    result_q    <= '1;
                                    result_hi_q <= src1_i;
                                    overflow_q  <= 1'b0;
                                    valid_q     <= 1'b1;
                                    state_q     <= DONE;
                                end else begin
                                    prod_q  <= {{WIDTH{1'b0}}, src1_i};
                                    opb_q   <= src2_i;
                                    cnt_q   <= CNT_W'(WIDTH);
                                    state_q <= DIV;
                                end
                            end else
`endif
                            begin
                                prod_q  <= {{WIDTH{1'b0}}, src1_i};
                                opb_q   <= src2_i;
                                cnt_q   <= CNT_W'(WIDTH);
                                state_q <= MUL;
                            end
                        end else begin
                            result_q    <= alu_result;
                            result_hi_q <= '0;
                            overflow_q  <= alu_ovf;
                            valid_q     <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                MUL: begin
                    prod_q <= mul_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        result_q    <= mul_d[WIDTH-1:0];
                        result_hi_q <= mul_d[2*WIDTH-1:WIDTH];
                        overflow_q  <= 1'b0;
                        valid_q     <= 1'b1;
                        state_q     <= DONE;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                DIV: begin
                    prod_q <= div_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        result_q    <= div_d[WIDTH-1:0];
                        result_hi_q <= div_d[2*WIDTH-1:WIDTH];
                        overflow_q  <= 1'b0;
                        valid_q     <= 1'b1;
                        state_q     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o     = (state_q == IDLE) && !rst_i;
    assign valid_o     = valid_q;
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign overflow_o  = overflow_q;
    assign zero_o      = valid_q && (result_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// tb_seq_alu : randomized self-checking bench for seq_alu against a
// behavioural model (honours SEQ_ALU_DIV_EN).  Rev 1.0
// ============================================================================
module tb_seq_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  src1_i;
    logic [W-1:0]  src2_i;
    logic [3:0]    ctrl_i;
    logic          valid_o;
    logic          ready_i;
    logic [W-1:0]  result_o;
    logic [W-1:0]  result_hi_o;
    logic          zero_o;
    logic          overflow_o;

    int n_checks = 0;
    int n_pass   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .ctrl_i      (ctrl_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o),
        .result_hi_o (result_hi_o),
        .zero_o      (zero_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: signed/unsigned arithmetic on 64-bit integers.
    function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] hi,
                                  output logic ov, output int lat);
        longint sa, sb, s;
        logic [63:0] p;
        longint maxv, minv;
        maxv = 64'sh7FFF_FFFF;
        minv = -64'sh8000_0000;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; hi = '0; ov = 1'b0; lat = 1;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin s = sa + sb; r = s[W-1:0]; ov = (s > maxv) || (s < minv); end
            4'b0110: begin s = sa - sb; r = s[W-1:0]; ov = (s > maxv) || (s < minv); end
            4'b0111: r = (sa < sb) ? 1 : 0;
            4'b1100: r = ~(a | b);
            4'b1101: r = ~(a & b);
            4'b1000: begin
                p = {32'b0, a} * {32'b0, b};
                r = p[31:0]; hi = p[63:32]; lat = W + 1;
            end
`ifdef SEQ_ALU_DIV_EN
            4'b1010: begin
                if (b == 0) begin r = '1; hi = a; lat = 1; end
                else begin r = a / b; hi = a % b; lat = W + 1; end
            end
`endif
            default: r = '0;
        endcase
    endfunction

    task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
        logic [W-1:0] er, eh, sr, sh;
        logic eo, sz, so;
        int el, lat, g;
        bit rdy_bad, unstable;
        model(c, a, b, er, eh, eo, el);
        @(negedge clk);
        g = 0;
        while (!ready_o && g < 50) begin @(negedge clk); g++; end
        check("ready_before", ready_o, 1);
        valid_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b;
        @(posedge clk); #1;
        lat = 1; rdy_bad = 0;
        while (!valid_o && lat < 100) begin
            if (ready_o) rdy_bad = 1;
            src1_i = $urandom; src2_i = $urandom; ctrl_i = 4'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency c=%b", c), lat, el);
        check("ready_busy", rdy_bad, 0);
        check($sformatf("result c=%b a=%h b=%h", c, a, b), result_o, er);
        check($sformatf("result_hi c=%b", c), result_hi_o, eh);
        check($sformatf("overflow c=%b", c), overflow_o, eo);
        check($sformatf("zero c=%b", c), zero_o, (er == 0));
        sr = result_o; sh = result_hi_o; sz = zero_o; so = overflow_o;
        unstable = 0;
        for (int i = 0; i < stall; i++) begin
            valid_i = 1'b1; src1_i = $urandom; src2_i = $urandom; ctrl_i = 4'($urandom);
            @(posedge clk); #1;
            if (!valid_o || result_o !== sr || result_hi_o !== sh || zero_o !== sz ||
                overflow_o !== so || ready_o) unstable = 1;
        end
        check("stall_stable", unstable, 0);
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0; valid_i = 1'b0;
        check("valid_drop", valid_o, 0);
        check("ready_after", ready_o, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   codes [11];
        logic [W-1:0] corners [5];
        logic [W-1:0] a, b;
        codes   = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'hD, 4'h8, 4'hA, 4'h3, 4'hF};
        corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        src1_i = '0; src2_i = '0; ctrl_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_result", result_o, 0);
        check("rst_result_hi", result_hi_o, 0);
        check("rst_zero", zero_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_ready", ready_o, 0);
        @(negedge clk); rst_i = 1'b0; #1;
        check("post_rst_ready", ready_o, 1);

        do_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
        do_op(4'b0110, 32'd5, 32'd5, 1);
        do_op(4'b0111, 32'h8000_0000, 32'h1, 0);
        do_op(4'b0111, 32'h1, 32'h8000_0000, 0);
        do_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        do_op(4'b1010, 32'd100, 32'd7, 0);
        do_op(4'b1010, 32'd9, 32'd0, 2);

        // Abort a multiply partway through.
        @(negedge clk);
        valid_i = 1'b1; ctrl_i = 4'b1000; src1_i = 32'hDEAD_BEEF; src2_i = 32'h1234_5678;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_i = 1'b1;
        #1;
        check("midrst_valid", valid_o, 0);
        check("midrst_result", result_o, 0);
        check("midrst_result_hi", result_hi_o, 0);
        check("midrst_zero", zero_o, 0);
        check("midrst_ready", ready_o, 0);
        @(negedge clk); rst_i = 1'b0; #1;
        check("midrst_ready_after", ready_o, 1);
        do_op(4'b0010, 32'd2, 32'd3, 0);

        for (int k = 0; k < 30; k++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            do_op(codes[$urandom_range(0, 10)], a, b, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
